// File: rtl/virtual_uart_fifo_if.sv
// AXI-lite bundle between the SoC/XDMA master and the virtual UART slave.
interface virtual_uart_fifo_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/virtual_uart_fifo.sv
// Virtual UART: AXI-lite slave with UartLite-style registers over RX/TX FIFOs.
// Optional core-TX-to-RX loopback is compiled in with VIRTUAL_UART_LOOPBACK_EN.
module virtual_uart_fifo_buf #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 16,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic [CNT_W-1:0] o_count,
   output logic             o_overflow
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_empty;
   logic             w_full;
   logic             w_do_push;
   logic             w_do_pop;

   // A pop on a full FIFO frees the slot the same-cycle push lands in.
   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == CNT_W'(DEPTH));
   assign w_do_pop   = i_pop & ~w_empty;
   assign w_do_push  = i_push & (~w_full | w_do_pop);
   assign o_data     = w_empty ? '0 : r_mem[r_rd_ptr];
   assign o_count    = r_count;
   assign o_overflow = i_push & ~w_do_push & ~i_flush;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock_i) begin
      if (reset_i || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
      end
   end

   // NOTE: the storage array is not reset; the count alone decides which entries are valid.
   always_ff @(posedge clock_i) begin
      if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
   end
endmodule

module virtual_uart_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int CHAR_WIDTH = 8,
   parameter int RX_DEPTH   = 16,
   parameter int TX_DEPTH   = 16
) (
   input  logic               clock_i,
   input  logic               reset_i,
   virtual_uart_fifo_if.slave s_axilite,
   output logic               int_core_o,
   output logic               int_host_o
);
   localparam int RX_CNT_W = $clog2(RX_DEPTH) + 1;
   localparam int TX_CNT_W = $clog2(TX_DEPTH) + 1;

   typedef enum logic [2:0] {
      REG_RX_FIFO, REG_TX_FIFO, REG_STATUS, REG_CTRL,
      REG_HOST_RX_PUSH, REG_HOST_TX_POP, REG_HOST_INT_ACK, REG_LEVELS
   } reg_e;

   logic                  r_awready, r_bvalid, r_arready, r_rvalid;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_int_en, r_rx_overrun, r_tx_overflow, r_int_core, r_int_host;
   logic                  w_wr_fire, w_rd_fire, w_loop;
   reg_e                  w_wr_reg, w_rd_reg;
   logic                  w_ctrl_wr, w_core_tx_wr, w_ack_wr, w_status_rd;
   logic                  w_rx_push, w_rx_pop, w_rx_flush, w_rx_ovf;
   logic                  w_tx_push, w_tx_pop, w_tx_flush, w_tx_ovf;
   logic [CHAR_WIDTH-1:0] w_rx_data, w_tx_data;
   logic [RX_CNT_W-1:0]   w_rx_count;
   logic [TX_CNT_W-1:0]   w_tx_count;
   logic                  w_rx_valid, w_rx_full, w_tx_empty, w_tx_full;
   logic [DATA_WIDTH-1:0] w_rd_data;
   logic                  w_unused;

   assign w_wr_fire    = r_awready & s_axilite.awvalid & s_axilite.wvalid;
   assign w_rd_fire    = r_arready & s_axilite.arvalid;
   assign w_wr_reg     = reg_e'(s_axilite.awaddr[4:2]);
   assign w_rd_reg     = reg_e'(s_axilite.araddr[4:2]);
   assign w_ctrl_wr    = w_wr_fire & (w_wr_reg == REG_CTRL);
   assign w_core_tx_wr = w_wr_fire & (w_wr_reg == REG_TX_FIFO);
   assign w_ack_wr     = w_wr_fire & (w_wr_reg == REG_HOST_INT_ACK);
   assign w_status_rd  = w_rd_fire & (w_rd_reg == REG_STATUS);
   assign w_rx_push    = (w_wr_fire & (w_wr_reg == REG_HOST_RX_PUSH)) | (w_core_tx_wr & w_loop);
   assign w_tx_push    = w_core_tx_wr & ~w_loop;
   assign w_rx_pop     = w_rd_fire & (w_rd_reg == REG_RX_FIFO);
   assign w_tx_pop     = w_rd_fire & (w_rd_reg == REG_HOST_TX_POP);
   assign w_rx_flush   = w_ctrl_wr & s_axilite.wdata[1];
   assign w_tx_flush   = w_ctrl_wr & s_axilite.wdata[0];

   virtual_uart_fifo_buf #(.WIDTH(CHAR_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clock_i(clock_i), .reset_i(reset_i), .i_push(w_rx_push), .i_pop(w_rx_pop),
      .i_flush(w_rx_flush), .i_data(s_axilite.wdata[CHAR_WIDTH-1:0]),
      .o_data(w_rx_data), .o_count(w_rx_count), .o_overflow(w_rx_ovf)
   );

   virtual_uart_fifo_buf #(.WIDTH(CHAR_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clock_i(clock_i), .reset_i(reset_i), .i_push(w_tx_push), .i_pop(w_tx_pop),
      .i_flush(w_tx_flush), .i_data(s_axilite.wdata[CHAR_WIDTH-1:0]),
      .o_data(w_tx_data), .o_count(w_tx_count), .o_overflow(w_tx_ovf)
   );

   assign w_rx_valid = (w_rx_count != '0);
   assign w_rx_full  = (w_rx_count == RX_CNT_W'(RX_DEPTH));
   assign w_tx_empty = (w_tx_count == '0);
   assign w_tx_full  = (w_tx_count == TX_CNT_W'(TX_DEPTH));

`ifdef VIRTUAL_UART_LOOPBACK_EN
   logic r_loopback;
   always_ff @(posedge clock_i) begin
      if (reset_i)        r_loopback <= 1'b0;
      else if (w_ctrl_wr) r_loopback <= s_axilite.wdata[2];
   end
   assign w_loop = r_loopback;
`else
   assign w_loop = 1'b0;
`endif

   always_comb begin
      w_rd_data = '0;
      case (w_rd_reg)
         REG_RX_FIFO:     w_rd_data = DATA_WIDTH'(w_rx_data);
         REG_STATUS:      w_rd_data = DATA_WIDTH'({w_loop, r_tx_overflow, r_rx_overrun, r_int_en,
                                                   w_tx_full, w_tx_empty, w_rx_full, w_rx_valid});
         REG_HOST_TX_POP: w_rd_data = DATA_WIDTH'(w_tx_data);
         REG_LEVELS:      w_rd_data = DATA_WIDTH'({16'(w_tx_count), 16'(w_rx_count)});
         default:         w_rd_data = '0;
      endcase
   end

   // Ready is a one-cycle pulse; the side effect commits on the edge that ends it.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_awready <= 1'b0;
         r_bvalid  <= 1'b0;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
      end else begin
         r_awready <= s_axilite.awvalid & s_axilite.wvalid & ~r_awready & ~r_bvalid;
         r_arready <= s_axilite.arvalid & ~r_arready & ~r_rvalid;
         if (w_wr_fire)             r_bvalid <= 1'b1;
         else if (s_axilite.bready) r_bvalid <= 1'b0;
         if (w_rd_fire) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
         end else if (s_axilite.rready) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_int_en      <= 1'b0;
         r_rx_overrun  <= 1'b0;
         r_tx_overflow <= 1'b0;
         r_int_core    <= 1'b0;
         r_int_host    <= 1'b0;
      end else begin
         r_int_core <= r_int_en & (w_rx_valid | w_tx_empty);
         if (w_ctrl_wr) r_int_en <= s_axilite.wdata[4];
         if (w_rx_ovf)         r_rx_overrun  <= 1'b1;
         else if (w_status_rd) r_rx_overrun  <= 1'b0;
         if (w_tx_ovf)         r_tx_overflow <= 1'b1;
         else if (w_status_rd) r_tx_overflow <= 1'b0;
         if (w_tx_push && !w_tx_ovf) r_int_host <= 1'b1;
         else if (w_ack_wr)          r_int_host <= 1'b0;
      end
   end

   assign s_axilite.awready = r_awready;
   assign s_axilite.wready  = r_awready;
   assign s_axilite.bvalid  = r_bvalid;
   assign s_axilite.bresp   = 2'b00;
   assign s_axilite.arready = r_arready;
   assign s_axilite.rvalid  = r_rvalid;
   assign s_axilite.rdata   = r_rdata;
   assign s_axilite.rresp   = 2'b00;
   assign int_core_o        = r_int_core;
   assign int_host_o        = r_int_host;

   assign w_unused = ^{s_axilite.wstrb, s_axilite.wdata[DATA_WIDTH-1:CHAR_WIDTH],
                       s_axilite.awaddr[ADDR_WIDTH-1:5], s_axilite.awaddr[1:0],
                       s_axilite.araddr[ADDR_WIDTH-1:5], s_axilite.araddr[1:0]};
endmodule

// File: doc/virtual_uart_fifo.md
Name: virtual_uart_fifo

Overview:
- Parametrised successor to the single-register virtual UART: an AXI-lite slave exposing UartLite-compatible core registers, backed by RX and TX FIFOs of configurable depth and character width.
- A host side (reached via XDMA on the same AXI-lite port) pushes RX characters, pops TX characters and acknowledges its interrupt.
- Sits on the SoC peripheral bus in place of a physical UART for simulation and bring-up.

Parameters:
- DATA_WIDTH, 32, AXI-lite data width; must be 32.
- ADDR_WIDTH, 32, AXI-lite address width; only bits [4:2] are decoded.
- CHAR_WIDTH, 8, character width, 5..16; stored in bits [CHAR_WIDTH-1:0] of data registers.
- RX_DEPTH, 16, RX FIFO entries; power of two, at least 2.
- TX_DEPTH, 16, TX FIFO entries; power of two, at least 2.

Ports:
- clock_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- s_axilite_awaddr/awvalid/awready  in/in/out  ADDR_WIDTH/1/1  write address channel.
- s_axilite_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel; wstrb is ignored.
- s_axilite_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
- s_axilite_araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1  read address channel.
- s_axilite_rdata/rresp/rvalid/rready  out/out/out/in  DATA_WIDTH/2/1/1  read data channel.
- int_core_o  out  1  level interrupt to core.
- int_host_o  out  1  sticky interrupt to host/XDMA.

Behaviour:
- Clock and reset: one clock, clock_i. Reset is synchronous and active-high on reset_i.
- Register map:
  - 0x00 RX_FIFO: core read pops.
  - 0x04 TX_FIFO: core write pushes; reads 0.
  - 0x08 STATUS: read-only.
  - 0x0C CTRL: write-only; reads 0.
  - 0x10 HOST_RX_PUSH: write pushes into RX FIFO.
  - 0x14 HOST_TX_POP: read pops from TX FIFO.
  - 0x18 HOST_INT_ACK: write clears int_host_o.
  - 0x1C LEVELS: [15:0] RX count, [31:16] TX count.
- STATUS bits:
  - 0 RX valid (RX count != 0).
  - 1 RX full.
  - 2 TX empty.
  - 3 TX full.
  - 4 interrupt enable.
  - 5 RX overrun (sticky).
  - 6 TX overflow (sticky).
  - Bits 5 and 6 clear on any STATUS read.
- CTRL bits:
  - 0 flushes TX FIFO (self-clearing).
  - 1 flushes RX FIFO (self-clearing).
  - 4 interrupt enable (stored).
  - 2 loopback enable (see Optional Feature).
- Write handshake:
  - Accepted only when awvalid and wvalid are both high, and no B response is pending.
  - awready and wready pulse high together for exactly one cycle.
  - Register effect and bvalid rise on the next cycle; bresp is always OKAY.
  - bvalid holds until bready.
- Read handshake:
  - Accepted only when arvalid is high and no R response is pending.
  - arready pulses for one cycle.
  - rdata, rvalid and the pop side effect occur on the next cycle; rresp is always OKAY.
  - rvalid and rdata hold until rready.
  - Reads and writes are independent and may complete in the same cycle.
- FIFOs:
  - Circular buffers with wrap-around pointers and count width $clog2(DEPTH)+1.
  - Data is zero-extended on read.
  - Pop when empty: returns 0, no state change.
  - Push when full: data dropped; set RX overrun (RX FIFO) or TX overflow (TX FIFO).
  - Push and pop on the same FIFO in the same cycle: both occur, count unchanged. If the FIFO is empty, the pop returns 0 and the push is stored. If the FIFO is full, the pop frees the slot for the push.
  - Flush combined with a same-cycle push: flush wins.
- Interrupts:
  - int_core_o = INT_EN & (RX count != 0 | TX empty), registered, one cycle latency.
  - int_host_o sets on every accepted TX push and clears on a HOST_INT_ACK write.
  - A push and an ack in the same cycle leaves int_host_o set.
- Reset values:
  - All ready, valid and interrupt outputs are 0; rdata = 0; bresp and rresp = OKAY.
  - FIFOs empty, sticky bits 0, INT_EN 0.
- Reset mid-transaction: pending B and R responses are discarded; no side effect is committed.

Optional Feature:
- Macro: VIRTUAL_UART_LOOPBACK_EN.
- Defined: CTRL bit 2 is stored. When it is set, core TX pushes go into the RX FIFO instead of the TX FIFO, with RX overrun rules applied. int_host_o does not set on those pushes. STATUS bit 7 reflects loopback.
- Not defined: CTRL bit 2 is ignored and STATUS bit 7 reads 0.

Test Plan:
1. Reset, then read STATUS -> 0x00000004, int_core_o = 0, int_host_o = 0.
2. Host writes 0x41, 0x42 to 0x10; core reads 0x00 twice, then a third time -> rdata 0x41, 0x42, then 0. LEVELS RX goes 2, 1, 0.
3. Core writes 17 characters to 0x04 with TX_DEPTH=16 -> STATUS bit 3 = 1 and bit 6 = 1; second STATUS read shows bit 6 = 0. Host pops 16 values in order and int_host_o stays 1 until a write to 0x18.
4. CTRL = 0x10, then host pushes 0x55 -> int_core_o = 1 one cycle after RX count becomes 1. CTRL = 0x12 flushes RX; int_core_o remains 1 because TX is empty.
5. Same-cycle core read of 0x00 with RX count 16 and host write 0x10 -> count stays 16, no overrun. Hold bready low for 5 cycles -> bvalid held, no new write accepted.
6. With VIRTUAL_UART_LOOPBACK_EN, CTRL = 0x04 and core writes 0x7E to 0x04 -> RX count 1, TX count 0, core read returns 0x7E, int_host_o = 0.
